// File: rtl/gmii_arb_pkg.sv
// gmii_arb_pkg
//   Shared types and defaults for the GMII transmit arbiter.
//   arb_state_t  : arbiter FSM states
//   arb_client_t : client index (0 = UDP video engine, 1 = ARP/ICMP responder)
package gmii_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XMIT  = 2'd2,
    IFG   = 2'd3
  } arb_state_t;

  typedef logic arb_client_t;

  localparam int GMII_IFG_DEFAULT       = 12;
  localparam int GMII_MAX_FRAME_DEFAULT = 1526;
  localparam int FRAME_CNT_W            = 11;

endpackage

// File: rtl/gmii_tx_arbiter_if.sv
// gmii_tx_arbiter_if
//   Client-side bundle of the two frame sources sharing the GMII TX path.
//   req0/req1     : frame slot request, held until the frame ends
//   gnt0/gnt1     : grant back to the client (one-hot or zero)
//   tx_en0/tx_en1 : client frame-valid, GMII format
//   txd0/txd1     : client byte
//   modport master : the clients
//   modport slave  : the arbiter
interface gmii_tx_arbiter_if;
  logic       req0;
  logic       req1;
  logic       gnt0;
  logic       gnt1;
  logic       tx_en0;
  logic       tx_en1;
  logic [7:0] txd0;
  logic [7:0] txd1;

  modport master (
    output req0, req1, tx_en0, tx_en1, txd0, txd1,
    input  gnt0, gnt1
  );

  modport slave (
    input  req0, req1, tx_en0, tx_en1, txd0, txd1,
    output gnt0, gnt1
  );
endinterface

// File: rtl/gmii_arb_pick.sv
// gmii_arb_pick
//   Chooses which requesting client wins the next frame slot.
//   Build option GMII_ARB_RR_EN:
//     defined   : round-robin, ties go to the client not last served;
//                 ports gmii_tx_clk/rst_n/upd/served exist only in this build
//     undefined : fixed priority, client 0 wins ties
//   Ports:
//     gmii_tx_clk, rst_n : clock / synchronous active-low reset (RR only)
//     upd, served        : strobe + client index recorded as last served (RR only)
//     req0, req1         : current requests
//     winner             : selected client (only meaningful when a req is high)
module gmii_arb_pick
  import gmii_arb_pkg::*;
(
`ifdef GMII_ARB_RR_EN
  input  logic        gmii_tx_clk,
  input  logic        rst_n,
  input  logic        upd,
  input  arb_client_t served,
`endif
  input  logic        req0,
  input  logic        req1,
  output arb_client_t winner
);

`ifdef GMII_ARB_RR_EN
  arb_client_t last_q;

  // Resets to 1 so that client 0 takes the first tie.
  always_ff @(posedge gmii_tx_clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (upd) begin
      last_q <= served;
    end
  end

  always_comb begin
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ~last_q;
    end else if (req1) begin
      winner = 1'b1;
    end
  end
`else
  assign winner = !req0 && req1;
`endif

endmodule

// File: rtl/gmii_tx_arbiter.sv
// gmii_tx_arbiter
//   Shares one GMII transmit path between two frame sources on a whole-frame
//   basis, enforces a minimum inter-frame gap and truncates runaway frames.
//   Build option GMII_ARB_RR_EN selects round-robin tie-breaking (default is
//   fixed priority, client 0 first).
//   Ports:
//     gmii_tx_clk : transmit clock (only clock)
//     rst_n       : synchronous active-low reset
//     cli         : client bundle (req/gnt/tx_en/txd for both clients)
//     gmii_tx_en  : arbitrated frame-valid, registered
//     gmii_txd    : arbitrated byte, registered
//     busy        : FSM not in IDLE
//     wdog_err    : one-cycle pulse when a frame is truncated
//
//   state | meaning
//   IDLE  | no owner; evaluates requests
//   GRANT | owner granted, waiting for its tx_en to rise (or req to drop)
//   XMIT  | owner's frame passing through; watchdog counting
//   IFG   | enforced gap after a frame, gnt low
module gmii_tx_arbiter
  import gmii_arb_pkg::*;
#(
  parameter int IFG_CYCLES       = GMII_IFG_DEFAULT,
  parameter int MAX_FRAME_CYCLES = GMII_MAX_FRAME_DEFAULT
) (
  input  logic              gmii_tx_clk,
  input  logic              rst_n,
  gmii_tx_arbiter_if.slave  cli,
  output logic              gmii_tx_en,
  output logic [7:0]        gmii_txd,
  output logic              busy,
  output logic              wdog_err
);

  localparam int GAP_W = $clog2(IFG_CYCLES + 1);
  // The GRANT-cycle byte is not counted, so the frame hits the limit when the
  // counter is one short of it while another byte is still arriving.
  localparam logic [FRAME_CNT_W-1:0] FRAME_LAST = FRAME_CNT_W'(MAX_FRAME_CYCLES - 1);
  localparam logic [GAP_W-1:0]       GAP_LAST   = GAP_W'(IFG_CYCLES - 1);

  arb_state_t             state_q, state_d;
  arb_client_t            owner_q, owner_d, winner;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic [GAP_W-1:0]       gap_cnt_q;
  logic                   req_sel, tx_en_sel, wdog_hit, owned;
  logic [7:0]             txd_sel;

  assign req_sel   = owner_q ? cli.req1   : cli.req0;
  assign tx_en_sel = owner_q ? cli.tx_en1 : cli.tx_en0;
  assign txd_sel   = owner_q ? cli.txd1   : cli.txd0;
  assign owned     = (state_q == GRANT) || (state_q == XMIT);
  assign wdog_hit  = (state_q == XMIT) && tx_en_sel && (frame_cnt_q == FRAME_LAST);

  assign cli.gnt0 = owned && !owner_q;
  assign cli.gnt1 = owned &&  owner_q;
  assign busy     = (state_q != IDLE);

  gmii_arb_pick u_pick (
`ifdef GMII_ARB_RR_EN
    .gmii_tx_clk (gmii_tx_clk),
    .rst_n       (rst_n),
    .upd         ((state_q == GRANT) && (state_d == XMIT)),
    .served      (owner_q),
`endif
    .req0        (cli.req0),
    .req1        (cli.req1),
    .winner      (winner)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (cli.req0 || cli.req1) begin
          state_d = GRANT;
          owner_d = winner;
        end
      end
      GRANT: begin
        // A frame that has started wins over a late req drop.
        if (tx_en_sel) begin
          state_d = XMIT;
        end else if (!req_sel) begin
          state_d = IDLE;
        end
      end
      XMIT: begin
        if (!tx_en_sel || wdog_hit) begin
          state_d = IFG;
        end
      end
      IFG: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge gmii_tx_clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      frame_cnt_q <= '0;
      gap_cnt_q   <= '0;
      gmii_tx_en  <= 1'b0;
      gmii_txd    <= 8'h00;
      wdog_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;

      if ((state_q != XMIT) && (state_d == XMIT)) begin
        frame_cnt_q <= '0;
      end else if ((state_q == XMIT) && tx_en_sel && (frame_cnt_q != '1)) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end

      if ((state_q != IFG) && (state_d == IFG)) begin
        gap_cnt_q <= '0;
      end else if (state_q == IFG) begin
        gap_cnt_q <= gap_cnt_q + 1'b1;
      end

      if (owned && !wdog_hit) begin
        gmii_tx_en <= tx_en_sel;
        gmii_txd   <= txd_sel;
      end else begin
        gmii_tx_en <= 1'b0;
        gmii_txd   <= 8'h00;
      end

      wdog_err <= wdog_hit;
    end
  end

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
module tb_gmii_tx_arbiter;

  logic       gmii_tx_clk = 1'b0;
  logic       rst_n;
  logic       gmii_tx_en;
  logic [7:0] gmii_txd;
  logic       busy;
  logic       wdog_err;

  int errors = 0;
  int checks = 0;

`ifdef GMII_ARB_RR_EN
  int exp_order[4] = '{0, 1, 0, 1};
`else
  int exp_order[4] = '{0, 0, 1, 1};
`endif

  gmii_tx_arbiter_if bus ();

  gmii_tx_arbiter #(
    .IFG_CYCLES       (12),
    .MAX_FRAME_CYCLES (100)
  ) dut (
    .gmii_tx_clk (gmii_tx_clk),
    .rst_n       (rst_n),
    .cli         (bus),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_txd    (gmii_txd),
    .busy        (busy),
    .wdog_err    (wdog_err)
  );

  always #5 gmii_tx_clk = ~gmii_tx_clk;

  task automatic tick();
    @(posedge gmii_tx_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int w = 0;
    while (busy && w < limit) begin
      tick();
      w++;
    end
    chk(tag, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int hi, bad, wd, g1, w, who, pend0, pend1;

    bus.req0 = 0; bus.req1 = 0;
    bus.tx_en0 = 0; bus.tx_en1 = 0;
    bus.txd0 = 8'h00; bus.txd1 = 8'h00;
    rst_n = 0;
    repeat (3) tick();

    // reset state
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_gnt1", bus.gnt1, 0);
    chk("rst_tx_en", gmii_tx_en, 0);
    chk("rst_txd", gmii_txd, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_wdog", wdog_err, 0);
    rst_n = 1;
    tick();
    chk("idle_busy", busy, 0);

    // single client, 64-byte frame
    bus.req0 = 1;
    tick();
    chk("single_gnt0", bus.gnt0, 1);
    chk("single_gnt1", bus.gnt1, 0);
    hi = 0; bad = 0;
    for (int k = 0; k < 64; k++) begin
      bus.tx_en0 = 1; bus.txd0 = 8'(k);
      tick();
      if (gmii_tx_en) hi++;
      if (gmii_txd !== 8'(k)) bad++;
    end
    bus.tx_en0 = 0; bus.txd0 = 8'h00; bus.req0 = 0;
    tick();
    chk("single_bytes", bad, 0);
    chk("single_hi", hi, 64);
    chk("single_end_en", gmii_tx_en, 0);
    chk("single_end_gnt", bus.gnt0, 0);
    chk("single_ifg_busy", busy, 1);
    repeat (11) tick();
    chk("ifg_last_busy", busy, 1);
    tick();
    chk("ifg_done", busy, 0);

    // isolation: client 1 misbehaves while client 0 owns the path
    bus.tx_en1 = 1; bus.txd1 = 8'hAA;
    tick();
    chk("iso_idle_en", gmii_tx_en, 0);
    chk("iso_idle_txd", gmii_txd, 8'h00);
    bus.req0 = 1;
    tick();
    chk("iso_gnt0", bus.gnt0, 1);
    bad = 0; g1 = 0;
    for (int k = 0; k < 16; k++) begin
      bus.tx_en0 = 1; bus.txd0 = 8'h50 + 8'(k);
      tick();
      if (gmii_txd !== (8'h50 + 8'(k)) || gmii_tx_en !== 1'b1) bad++;
      if (bus.gnt1) g1++;
    end
    bus.tx_en0 = 0; bus.txd0 = 8'h00; bus.req0 = 0;
    tick();
    if (bus.gnt1) g1++;
    chk("iso_bytes", bad, 0);
    chk("iso_gnt1", g1, 0);
    wait_idle("iso_idle_timeout", 30);
    bus.tx_en1 = 0; bus.txd1 = 8'h00;

    // watchdog: 200-cycle frame against a 100-cycle limit
    bus.req0 = 1;
    tick();
    chk("wd_gnt0", bus.gnt0, 1);
    hi = 0; wd = 0; bad = 0;
    for (int k = 0; k < 200; k++) begin
      bus.tx_en0 = 1; bus.txd0 = 8'(k);
      tick();
      if (gmii_tx_en) hi++;
      if (wdog_err) wd++;
      if (k < 100 && gmii_txd !== 8'(k)) bad++;
      if (k == 100) begin
        chk("wd_force_en", gmii_tx_en, 0);
        chk("wd_pulse", wdog_err, 1);
        chk("wd_gnt_drop", bus.gnt0, 0);
        bus.req0 = 0;
      end
      if (k == 111) chk("wd_ifg_busy", busy, 1);
      if (k == 112) chk("wd_idle", busy, 0);
    end
    bus.tx_en0 = 0; bus.txd0 = 8'h00;
    tick();
    chk("wd_hi", hi, 100);
    chk("wd_count", wd, 1);
    chk("wd_bytes", bad, 0);
    chk("wd_end_busy", busy, 0);

    // reset in the middle of a frame
    bus.req0 = 1;
    tick();
    for (int k = 0; k < 10; k++) begin
      bus.tx_en0 = 1; bus.txd0 = 8'(k + 1);
      tick();
    end
    chk("mid_pre_en", gmii_tx_en, 1);
    rst_n = 0;
    tick();
    chk("mid_rst_en", gmii_tx_en, 0);
    chk("mid_rst_txd", gmii_txd, 8'h00);
    chk("mid_rst_gnt0", bus.gnt0, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wdog", wdog_err, 0);

    // no gap after reset, then cancel before tx_en
    rst_n = 1;
    bus.tx_en0 = 0; bus.txd0 = 8'h00; bus.req0 = 0;
    bus.req1 = 1;
    tick();
    chk("cancel_gnt1", bus.gnt1, 1);
    bus.req1 = 0;
    tick();
    chk("cancel_busy", busy, 0);
    chk("cancel_gnt1_drop", bus.gnt1, 0);
    bus.req1 = 1;
    tick();
    chk("cancel_regnt", bus.gnt1, 1);
    bus.req1 = 0;
    tick();
    chk("cancel_idle", busy, 0);

    // tie: both clients request together, two 60-byte frames each
    pend0 = 2; pend1 = 2;
    bus.req0 = 1; bus.req1 = 1;
    for (int f = 0; f < 4; f++) begin
      w = 0;
      while (!(bus.gnt0 || bus.gnt1) && w < 60) begin
        tick();
        w++;
      end
      chk("tie_grant_seen", bus.gnt0 | bus.gnt1, 1);
      chk("tie_onehot", bus.gnt0 & bus.gnt1, 0);
      who = bus.gnt1 ? 1 : 0;
      chk("tie_order", who, exp_order[f]);
      if (f > 0) chk("tie_gap", w + 1, 14);
      bad = 0;
      for (int k = 0; k < 60; k++) begin
        if (who == 0) begin
          bus.tx_en0 = 1; bus.txd0 = 8'(k + 8'h20);
        end else begin
          bus.tx_en1 = 1; bus.txd1 = 8'(k + 8'h80);
        end
        tick();
        if (gmii_tx_en !== 1'b1) bad++;
        if (gmii_txd !== 8'(k + (who == 0 ? 8'h20 : 8'h80))) bad++;
      end
      if (who == 0) begin
        bus.tx_en0 = 0; bus.txd0 = 8'h00;
        pend0--;
        if (pend0 == 0) bus.req0 = 0;
      end else begin
        bus.tx_en1 = 0; bus.txd1 = 8'h00;
        pend1--;
        if (pend1 == 0) bus.req1 = 0;
      end
      tick();
      chk("tie_bytes", bad, 0);
      chk("tie_end_en", gmii_tx_en, 0);
    end
    wait_idle("tie_idle_timeout", 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gmii_tx_arbiter.md
# gmii_tx_arbiter

Shares the single GMII transmit path between two frame sources: the UDP video stream engine (client 0) and the ARP/ICMP responder (client 1). Grants one client at a time on a whole-frame basis, muxes its byte stream onto the `gmii_tx_en`/`gmii_txd` signals that drive the RGMII transmitter, and enforces a minimum inter-frame gap. A watchdog truncates runaway frames. All logic runs in the `gmii_tx_clk` domain.

## Interface
- `IFG_CYCLES`, 12: idle cycles the arbiter holds in IFG after each frame.
- `MAX_FRAME_CYCLES`, 1526: watchdog limit on `tx_en` high cycles per frame.
- `gmii_tx_clk` in 1: GMII transmit clock, the only clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `req0` / `req1` in 1: client requests a frame slot; held high until its frame ends.
- `gnt0` / `gnt1` out 1: grant, one-hot or zero.
- `tx_en0` / `tx_en1` in 1: client frame-valid, in GMII format.
- `txd0` / `txd1` in 8: client byte.
- `gmii_tx_en` out 1: arbitrated frame-valid, to the RGMII transmitter.
- `gmii_txd` out 8: arbitrated byte.
- `busy` out 1: high in any state other than IDLE.
- `wdog_err` out 1: one-cycle pulse when a frame is truncated.

## Operation
- States:
  - **IDLE**: if any req, select a winner, then next edge assert its gnt and go to GRANT.
  - **GRANT**: on rising tx_en of the granted client go to XMIT. If the client drops req before tx_en, deassert gnt and return to IDLE with no gap.
  - **XMIT**: first cycle granted tx_en=0, deassert gnt and go to IFG. If the frame counter reaches MAX_FRAME_CYCLES while tx_en is still 1:
    - force gmii_tx_en=0 from the next cycle;
    - pulse wdog_err;
    - deassert gnt;
    - go to IFG.
  - **IFG**: gap counter runs 1..IFG_CYCLES, then go to IDLE.
- Datapath registers:
  - While in GRANT/XMIT: gmii_tx_en(t+1)=tx_enX(t) and gmii_txd(t+1)=txdX(t), where X is the granted client.
  - In IDLE/IFG: gmii_tx_en=0 and gmii_txd=0.
- The non-granted client's tx_en and txd are ignored entirely.
- The frame counter is 11 bits, saturating. It clears on entry to XMIT and increments each XMIT cycle with tx_en=1.
- The gap counter is $clog2(IFG_CYCLES+1) bits and clears on IFG entry.
- Simultaneous req0 and req1 in IDLE: the winner follows the policy under Configuration.
- A req that arrives during XMIT/IFG is held pending. It is evaluated only in IDLE.
- Reset values: gnt0=gnt1=0, gmii_tx_en=0, gmii_txd=8'h00, busy=0, wdog_err=0, state=IDLE, counters=0.
- Reset asserted mid-frame:
  - outputs go to their reset values at the next edge;
  - the frame is truncated with no wdog_err;
  - no gap is enforced after reset.

## Timing
- req seen in IDLE at cycle t gives gnt at t+1.
- Byte latency from client to GMII output is 1 cycle.
- Frame end, first tx_enX=0 at cycle t:
  - gnt low at t+1;
  - gmii_tx_en low at t+1;
  - IFG occupies t+1..t+IFG_CYCLES;
  - IDLE at t+IFG_CYCLES+1;
  - earliest next gnt at t+IFG_CYCLES+2.
- The gap on gmii_tx_en is therefore ≥ IFG_CYCLES+2 cycles.
- Back-to-back requests from the same client get the same minimum gap.
- wdog_err is asserted in the cycle gmii_tx_en is first forced low.

## Configuration
- `GMII_ARB_RR_EN` defined: round-robin.
  - A last-served pointer updates on every XMIT entry.
  - On simultaneous requests, the client not last served wins.
  - The pointer resets to 1, so client 0 wins the first tie.
- `GMII_ARB_RR_EN` undefined: fixed priority, client 0 always wins ties. The pointer register is not built.

## Structure
- Shared package `gmii_arb_pkg` holds:
  - state enum `arb_state_t` {IDLE, GRANT, XMIT, IFG};
  - client index typedef `arb_client_t` (1 bit);
  - constants `GMII_IFG_DEFAULT`=12 and `GMII_MAX_FRAME_DEFAULT`=1526.
- One sub-module, `gmii_arb_pick`, is natural. It takes req0/req1, an update strobe and the winner, and holds the round-robin pointer under the macro.
- FSM, counters and the output mux live in the top module.

## Test plan
- Single client: req0 with a 64-byte frame (tx_en0 high 64 cycles, txd0=incrementing from 8'h00).
  - gnt0 one cycle after req0;
  - gmii_txd reproduces 00..3F delayed 1 cycle;
  - gmii_tx_en high for exactly 64 cycles.
- Tie: req0 and req1 both raised in the same cycle, each sending two 60-byte frames.
  - RR build: grant order 0,1,0,1.
  - Fixed build: order 0,0,1,1.
  - Every gap on gmii_tx_en ≥ 14 cycles.
- Isolation: client 1 drives tx_en1=1 and txd1=8'hAA while client 0 holds the grant.
  - gmii_txd never equals 8'hAA while tx_en0 frame bytes ≠ AA.
  - gnt1 stays 0.
- Watchdog: MAX_FRAME_CYCLES=100 and client 0 holds tx_en0 for 200 cycles.
  - gmii_tx_en high for 100 cycles;
  - wdog_err pulses once;
  - gnt0 drops;
  - the FSM re-enters IDLE after the gap.
- Cancel and reset:
  - req1 granted, then dropped before tx_en1: IDLE next cycle, no gap.
  - rst_n low in the middle of a frame: gmii_tx_en=0, gnt=0, busy=0 at the next edge.
